// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller.
package serial_add_pkg;

    // Controller states; the unused encoding 2'd3 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand bits consumed per cycle by the adder slice.
    localparam int unsigned PAIR_BITS = 2;

endpackage

// File: rtl/serial_add_ctrl_slice.sv
// Combinational 2-bit full adder slice driven by the serial controller.
module add2_slice (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] S,
    output logic       Cout
);

    logic c_mid;

    // Two ripple-connected full-adder bits.
    always_comb begin
        S[0]  = A[0] ^ B[0] ^ Cin;
        c_mid = (A[0] & B[0]) | (A[0] & Cin) | (B[0] & Cin);
        S[1]  = A[1] ^ B[1] ^ c_mid;
        Cout  = (A[1] & B[1]) | (A[1] & c_mid) | (B[1] & c_mid);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial two-bits-per-cycle adder controller.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output Ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned N  = WIDTH / PAIR_BITS;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result_next;
    logic [1:0]       slice_s;
    logic             slice_cout;
    logic             last_pair;

`ifdef SERIAL_ADD_OVF_EN
    logic msb_a;
    logic msb_b;
`endif

    assign last_pair = (count == LAST);

    add2_slice u_slice (
        .A    (op_a[1:0]),
        .B    (op_b[1:0]),
        .Cin  (carry),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    // The low pair of the partial result is never read again, so the
    // partial register only keeps the upper WIDTH-2 bits.
    generate
        if (WIDTH > PAIR_BITS) begin : g_wide
            logic [WIDTH-1:PAIR_BITS] partial;

            assign result_next = {slice_s, partial[WIDTH-1:PAIR_BITS]};

            // Shift finished pairs in from the MSB end while running.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    partial <= '0;
                end else if (state == RUN) begin
                    partial <= result_next[WIDTH-1:PAIR_BITS];
                end
            end
        end else begin : g_narrow
            assign result_next = slice_s;
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = Start ? RUN : IDLE;
            RUN:     state_next = last_pair ? DONE : RUN;
            DONE:    state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy and Done are flops decoded from the upcoming state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_next == RUN);
            Done <= (state_next == DONE);
        end
    end

    // Operand capture, per-pair shifting and result update on DONE entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            count <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            msb_a <= 1'b0;
            msb_b <= 1'b0;
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    op_a  <= op_a >> PAIR_BITS;
                    op_b  <= op_b >> PAIR_BITS;
                    carry <= slice_cout;
                    count <= count + CW'(1);
                    if (last_pair) begin
                        Sum  <= result_next;
                        Cout <= slice_cout;
`ifdef SERIAL_ADD_OVF_EN
                        Ovf  <= (msb_a == msb_b) && (result_next[WIDTH-1] != msb_a);
`endif
                    end
                end
                default: begin
                    if (Start) begin
                        op_a  <= OpA;
                        op_b  <= OpB;
                        carry <= Cin;
                        count <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        msb_a <= OpA[WIDTH-1];
                        msb_b <= OpB[WIDTH-1];
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Honours SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int N = 4;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       Start;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic       Cin;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       Ovf;
`endif

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .OpA   (OpA),
        .OpB   (OpB),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one Start cycle; optionally queue the expected result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] s, input logic co, input logic ov, input bit push);
        exp_t e;
        Start = 1'b1;
        OpA   = a;
        OpB   = b;
        Cin   = ci;
        if (push) begin
            e.sum  = s;
            e.cout = co;
            e.ovf  = ov;
            e.cyc  = cyc + N + 1;
            sb.push_back(e);
        end
        tick(1);
        Start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compares every Done pulse against the scoreboard head.
    always @(negedge CLK) begin
        exp_t e;
        logic ovf_ok;
        if (!RST) begin
            if (Done && Busy) begin
                tests++;
                fails++;
                $display("FAIL overlap: Done=1 Busy=1 required not both (cycle %0d)", cyc);
            end
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_done: no Done in cycle %0d, got none", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: Done in cycle %0d, required no Done", cyc);
                end else begin
                    e = sb.pop_front();
                    ovf_ok = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_ok = (Ovf === e.ovf);
`endif
                    tests++;
                    if (Sum !== e.sum || Cout !== e.cout || cyc != e.cyc || !ovf_ok) begin
                        fails++;
                        $display("FAIL result: got sum=%0h cout=%0b cyc=%0d ovf_ok=%0b required sum=%0h cout=%0b cyc=%0d ovf=%0b",
                                 Sum, Cout, cyc, ovf_ok, e.sum, e.cout, e.cyc, e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        RST   = 1'b1;
        Start = 1'b0;
        OpA   = '0;
        OpB   = '0;
        Cin   = 1'b0;
        tick(3);
        @(negedge CLK);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_sum",  {24'd0, Sum},  32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf",  {31'd0, Ovf},  32'd0);
`endif
        tick(1);
        RST = 1'b0;
        tick(1);

        // Basic add with Busy window check.
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("busy_window", {31'd0, Busy}, 32'd1);
        end
        drain();
        tick(2);

        // Carry ripples through every pair.
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        tick(2);

        // Start while busy is ignored.
        issue(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(1);
        Start = 1'b1;
        OpA   = 8'h01;
        OpB   = 8'h01;
        tick(1);
        Start = 1'b0;
        drain();
        tick(4);

        // Back-to-back: second Start lands in the Done cycle.
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        tick(4);
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drain();
        tick(2);

        // Reset mid-run discards the operation.
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        drain();
        tick(1);
        issue(8'h77, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_sum",  {24'd0, Sum},  32'd0);
        check("midrst_cout", {31'd0, Cout}, 32'd0);
        tick(8);
        issue(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 1'b1);
        drain();
        tick(2);

        // Signed overflow boundaries.
        issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        drain();
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        tick(4);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL final_queue: %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequential driver for the 2-bit adder slice. It accepts two WIDTH-bit operands and a carry-in, then walks the operands two bits per cycle through a 2-bit full-adder slice, LSB pair first, with a registered ripple carry between pairs. It assembles the WIDTH-bit sum and the final carry-out, and reports completion with a one-cycle Done pulse. It sits directly upstream of the 2-bit adder, feeding A1/A0/B1/B0/Cin, and directly downstream of it, consuming S1/S0/Cout.

## Interface
- WIDTH, default 8: operand width. Must be even and ≥ 2. Pair count N = WIDTH/2.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  request. Sampled only when Busy=0.
- OpA  in  WIDTH  operand A, captured on an accepted Start.
- OpB  in  WIDTH  operand B, captured on an accepted Start.
- Cin  in  1  carry-in, captured on an accepted Start.
- Busy  out  1  high while pairs are being processed.
- Done  out  1  one-cycle pulse: result is valid.
- Sum  out  WIDTH  result, held until the next accepted Start.
- Cout  out  1  final carry-out, held with Sum.
- Ovf  out  1  signed overflow. Present only with SERIAL_ADD_OVF_EN.

## Operation
- The clock and reset are fixed: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, Start=1:
  - Capture OpA and OpB into shift registers.
  - Load the carry register with Cin.
  - Clear the pair counter.
  - Go to RUN.
- IDLE, Start=0: stay in IDLE.
- DONE, Start=0: go to IDLE.
- RUN, each cycle:
  - Slice inputs are A[1:0]/B[1:0] of the operand shift registers plus the carry register.
  - The slice's S1:S0 shifts into the result register from the MSB end (right shift by 2).
  - The slice's Cout loads the carry register.
  - Both operand registers shift right by 2.
  - The counter increments.
- RUN exit: after pair N-1 is processed, go to DONE.
- On entry to DONE:
  - The result register drives Sum.
  - The carry register drives Cout.
- Start while Busy=1 is ignored, with no queuing and no effect on the operation in progress.
- Sum and Cout keep their last values through IDLE and RUN. They update only on entry to DONE.
- The arithmetic is unsigned modulo 2^WIDTH: {Cout,Sum} = OpA + OpB + Cin, exactly WIDTH+1 bits.
- Reset at any time, including mid-RUN:
  - Next state is IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
  - Counter, carry and shift registers are cleared.
  - The partial result is discarded.

## Timing
- Values after reset: Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
- Start accepted in cycle t (high at the rising edge ending t):
  - Busy is high in cycles t+1 … t+N.
  - Done is high in cycle t+N+1 only.
  - Sum, Cout and Ovf are valid from t+N+1.
- Latency from Start to Done is N+1 cycles. For WIDTH=8 this is 5 cycles.
- Back-to-back: Start high in cycle t+N+1 (state DONE) is accepted. The next Done arrives at t+2N+2. Maximum throughput is one result per N+1 cycles.
- Done and Busy are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The counter is ceil(log2(N+1)) bits wide. It is compared against N-1 for exit.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - The Ovf port exists.
  - On DONE entry, Ovf = (OpA[MSB]==OpB[MSB]) && (Sum[MSB]!=OpA[MSB]). Operand MSBs are captured separately at Start.
  - Ovf is held with Sum.
- SERIAL_ADD_OVF_EN undefined:
  - No Ovf port.
  - No MSB capture flops.
  - All other behaviour is identical.

## Structure
- Package serial_add_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 recovers to IDLE);
  - the constant PAIR_BITS = 2.
- Sub-module add2_slice: combinational 2-bit full adder with ports A[1:0], B[1:0], Cin, S[1:0], Cout. It is instantiated once.
- The controller holds all state: FSM, counter, carry register, operand shift registers, result register.

## Test plan
- WIDTH=8, OpA=0x5A, OpB=0x3C, Cin=0, Start in cycle 0 -> Busy in cycles 1–4, Done in cycle 5, Sum=0x96, Cout=0.
- OpA=0xFF, OpB=0x01, Cin=0 -> Sum=0x00, Cout=1. Covers full carry ripple across all pairs.
- OpA=0xFF, OpB=0x00, Cin=1 -> Sum=0x00, Cout=1. Start pulsed again in cycle 2 -> ignored; exactly one Done.
- Back-to-back: 0x12+0x34 then, with Start in the Done cycle, 0x80+0x80 -> Sum=0x46 (Cout=0) at cycle 5, then Sum=0x00 (Cout=1) at cycle 10.
- RST asserted in cycle 3 of a run -> next cycle Busy=0, Sum=0, Cout=0, no Done. A new Start then completes normally.
- SERIAL_ADD_OVF_EN: 0x7F+0x01 -> Sum=0x80, Ovf=1. 0xFF+0x01 -> Ovf=0, Cout=1.
